// File: rtl/imem_resp.sv
// Instruction-memory responder: in-order fetch responses from a synchronous-read RAM,
// with a read stage and a 2-entry response queue, plus a program-load write port.
module imem_resp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] resp_addr,
  output logic              resp_err,
  input  logic              resp_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;

  logic              r_rd_valid;
  logic              r_rd_err;
  logic [DATA_W-1:0] r_rd_addr;

  logic [DATA_W-1:0] r_q_data [2];
  logic [DATA_W-1:0] r_q_addr [2];
  logic [1:0]        r_q_err;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_q_cnt;
  logic [1:0]        r_occ;

  logic              w_oor;
  logic              w_accept;
  logic              w_valid;
  logic              w_head_q;
  logic              w_pop;
  logic              w_q_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_rd_data;

  generate
    if (ADDR_W < DATA_W) begin : g_range
      assign w_oor = |req_addr[DATA_W-1:ADDR_W];
    end else begin : g_norange
      assign w_oor = 1'b0;
    end
  endgenerate

  assign req_ready = (r_occ < 2'd2) && !load_en;
  assign w_accept  = req_valid && req_ready;

  // Head is the oldest queued entry; the read stage is the head only when the queue is empty.
  assign w_head_q  = (r_q_cnt != 2'd0);
  assign w_valid   = w_head_q || r_rd_valid;
  assign w_pop     = w_valid && resp_ready;
  assign w_q_pop   = w_pop && w_head_q;
  assign w_push    = r_rd_valid && !(w_pop && !w_head_q);
  assign w_rd_data = r_rd_err ? '0 : r_ram_q;

  always_comb begin
    resp_valid = w_valid;
    resp_data  = '0;
    resp_addr  = '0;
    resp_err   = 1'b0;
    if (w_head_q) begin
      resp_data = r_q_data[r_rd_ptr];
      resp_addr = r_q_addr[r_rd_ptr];
      resp_err  = r_q_err[r_rd_ptr];
    end else if (r_rd_valid) begin
      resp_data = w_rd_data;
      resp_addr = r_rd_addr;
      resp_err  = r_rd_err;
    end
  end

  // RAM and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
    if (w_accept && !w_oor) begin
      r_ram_q <= r_mem[req_addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= w_rd_data;
      r_q_addr[r_wr_ptr] <= r_rd_addr;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_addr  <= '0;
      r_q_err    <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_q_cnt    <= 2'd0;
      r_occ      <= 2'd0;
    end else begin
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_rd_addr <= req_addr;
        r_rd_err  <= w_oor;
      end
      if (w_push) begin
        r_q_err[r_wr_ptr] <= r_rd_err;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_q_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_q_cnt <= r_q_cnt + {1'b0, w_push} - {1'b0, w_q_pop};
      r_occ   <= r_occ + {1'b0, w_accept} - {1'b0, w_pop};
    end
  end

endmodule
